// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the analog mux scan sequencer.
//   state_e : scan FSM states
//   ADDR_W  : channel address width (two 3-bit mux levels)
//   SEL_W   : select width of one 8:1 mux level
package mux_scan_pkg;

    localparam int ADDR_W = 6;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CONVERT = 2'd2,
        NEXT    = 2'd3
    } state_e;

endpackage

// File: rtl/scan_dwell_timer.sv
// Loadable down-counter shared by the settle and conversion-timeout phases.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_val_i on this edge (takes priority over counting)
//   load_val_i  : number of cycles to count
//   tc_o        : high during the last counted cycle (count == 1)
// Loading N makes tc_o high exactly N cycles after the load edge, so the
// consumer acts on the N-th edge. The counter parks at zero when idle.
module scan_dwell_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scan engine for the three-level 8:1 analog mux tree. Steps cur_addr over
// [ch_first .. ch_last] (6-bit wrap), settles, fires one ADC conversion per
// channel and waits for adc_done or a timeout.
//   start_i/stop_i          : scan control pulses (stop wins)
//   continuous_i, ch_first_i, ch_last_i, bank_i : config, latched at start
//   adc_done_i / adc_start_o: ADC handshake
//   F1/F2/F3_8ADD_{A,B,C}_o : mux selects (cur_addr[2:0], cur_addr[5:3], bank)
//   cur_addr_o, busy_o, ch_valid_o, frame_done_o, timeout_err_o : status
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1000,
    parameter int ADC_TIMEOUT   = 4096,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              continuous_i,
    input  logic [ADDR_W-1:0] ch_first_i,
    input  logic [ADDR_W-1:0] ch_last_i,
    input  logic [SEL_W-1:0]  bank_i,
    input  logic              adc_done_i,
    output logic              adc_start_o,
    output logic              F1_8ADD_A_o,
    output logic              F1_8ADD_B_o,
    output logic              F1_8ADD_C_o,
    output logic              F2_8ADD_A_o,
    output logic              F2_8ADD_B_o,
    output logic              F2_8ADD_C_o,
    output logic              F3_8ADD_A_o,
    output logic              F3_8ADD_B_o,
    output logic              F3_8ADD_C_o,
    output logic [ADDR_W-1:0] cur_addr_o,
    output logic              busy_o,
    output logic              ch_valid_o,
    output logic              frame_done_o,
    output logic              timeout_err_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [SEL_W-1:0]  bank_q, bank_d;
    logic              cont_q, cont_d;
    logic              stop_pend_q, stop_pend_d;
    logic              adc_start_q, adc_start_d;
    logic              ch_valid_q, ch_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              timeout_err_q, timeout_err_d;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_tc;

    scan_dwell_timer #(.CNT_W(CNT_W)) u_dwell (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        first_d       = first_q;
        last_d        = last_q;
        bank_d        = bank_q;
        cont_d        = cont_q;
        stop_pend_d   = stop_pend_q;
        adc_start_d   = 1'b0;
        ch_valid_d    = 1'b0;
        frame_done_d  = 1'b0;
        timeout_err_d = timeout_err_q;
        tmr_load      = 1'b0;
        tmr_val       = CNT_W'(SETTLE_CYCLES);

        unique case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (start_i && !stop_i) begin
                    first_d       = ch_first_i;
                    last_d        = ch_last_i;
                    bank_d        = bank_i;
                    cont_d        = continuous_i;
                    cur_addr_d    = ch_first_i;
                    timeout_err_d = 1'b0;
                    tmr_load      = 1'b1;
                    state_d       = SETTLE;
                end
            end
            SETTLE: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (tmr_tc) begin
                    adc_start_d = 1'b1;
                    tmr_load    = 1'b1;
                    tmr_val     = CNT_W'(ADC_TIMEOUT);
                    state_d     = CONVERT;
                end
            end
            CONVERT: begin
                // A stop here must let the running conversion finish.
                if (stop_i) begin
                    stop_pend_d = 1'b1;
                end
                // Done in the same cycle as the timeout counts as done.
                if (adc_done_i || tmr_tc) begin
                    ch_valid_d   = adc_done_i;
                    frame_done_d = (cur_addr_q == last_q);
                    if (!adc_done_i) begin
                        timeout_err_d = 1'b1;
                    end
                    state_d = (stop_i || stop_pend_q) ? IDLE : NEXT;
                end
            end
            NEXT: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (cur_addr_q == last_q) begin
                    if (cont_q) begin
                        cur_addr_d = first_q;
                        tmr_load   = 1'b1;
                        state_d    = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cur_addr_d = cur_addr_q + 1'b1;
                    tmr_load   = 1'b1;
                    state_d    = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cur_addr_q    <= '0;
            first_q       <= '0;
            last_q        <= '0;
            bank_q        <= '0;
            cont_q        <= 1'b0;
            stop_pend_q   <= 1'b0;
            adc_start_q   <= 1'b0;
            ch_valid_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            first_q       <= first_d;
            last_q        <= last_d;
            bank_q        <= bank_d;
            cont_q        <= cont_d;
            stop_pend_q   <= stop_pend_d;
            adc_start_q   <= adc_start_d;
            ch_valid_q    <= ch_valid_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign {F1_8ADD_C_o, F1_8ADD_B_o, F1_8ADD_A_o} = cur_addr_q[2:0];
    assign {F2_8ADD_C_o, F2_8ADD_B_o, F2_8ADD_A_o} = cur_addr_q[5:3];
    assign {F3_8ADD_C_o, F3_8ADD_B_o, F3_8ADD_A_o} = bank_q;

    assign cur_addr_o    = cur_addr_q;
    assign busy_o        = (state_q != IDLE);
    assign adc_start_o   = adc_start_q;
    assign ch_valid_o    = ch_valid_q;
    assign frame_done_o  = frame_done_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
module tb_mux_scan_sequencer;

    localparam int S = 4;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i, stop_i, continuous_i, adc_done_i;
    logic [5:0] ch_first_i, ch_last_i;
    logic [2:0] bank_i;
    logic       adc_start_o, busy_o, ch_valid_o, frame_done_o, timeout_err_o;
    logic       F1_8ADD_A_o, F1_8ADD_B_o, F1_8ADD_C_o;
    logic       F2_8ADD_A_o, F2_8ADD_B_o, F2_8ADD_C_o;
    logic       F3_8ADD_A_o, F3_8ADD_B_o, F3_8ADD_C_o;
    logic [5:0] cur_addr_o;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int vld_cnt = 0;
    int fd_cnt = 0;

    mux_scan_sequencer #(
        .SETTLE_CYCLES (S),
        .ADC_TIMEOUT   (T),
        .CNT_W         (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .continuous_i  (continuous_i),
        .ch_first_i    (ch_first_i),
        .ch_last_i     (ch_last_i),
        .bank_i        (bank_i),
        .adc_done_i    (adc_done_i),
        .adc_start_o   (adc_start_o),
        .F1_8ADD_A_o   (F1_8ADD_A_o),
        .F1_8ADD_B_o   (F1_8ADD_B_o),
        .F1_8ADD_C_o   (F1_8ADD_C_o),
        .F2_8ADD_A_o   (F2_8ADD_A_o),
        .F2_8ADD_B_o   (F2_8ADD_B_o),
        .F2_8ADD_C_o   (F2_8ADD_C_o),
        .F3_8ADD_A_o   (F3_8ADD_A_o),
        .F3_8ADD_B_o   (F3_8ADD_B_o),
        .F3_8ADD_C_o   (F3_8ADD_C_o),
        .cur_addr_o    (cur_addr_o),
        .busy_o        (busy_o),
        .ch_valid_o    (ch_valid_o),
        .frame_done_o  (frame_done_o),
        .timeout_err_o (timeout_err_o)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, to catch extra or missing pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ch_valid_o)   vld_cnt++;
            if (frame_done_o) fd_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int f1_sel();
        return int'({F1_8ADD_C_o, F1_8ADD_B_o, F1_8ADD_A_o});
    endfunction
    function automatic int f2_sel();
        return int'({F2_8ADD_C_o, F2_8ADD_B_o, F2_8ADD_A_o});
    endfunction
    function automatic int f3_sel();
        return int'({F3_8ADD_C_o, F3_8ADD_B_o, F3_8ADD_A_o});
    endfunction

    // Bounded wait for adc_start; returns with the result checked by caller.
    task automatic wait_adc_start(input int budget);
        int w;
        w = 0;
        while (!adc_start_o && w < budget) begin
            tick();
            w++;
        end
    endtask

    // One non-continuous scan. Reference: channel i = (first+i) mod 64,
    // len channels; channel drop_idx never gets adc_done (times out).
    task automatic run_scan(input int first, input int len, input int bnk,
                            input int drop_idx, input int lat);
        int last, ch, due, vld0, fd0, exp_vld;
        last    = (first + len - 1) % 64;
        vld0    = vld_cnt;
        fd0     = fd_cnt;
        exp_vld = 0;
        ch_first_i   = 6'(first);
        ch_last_i    = 6'(last);
        bank_i       = 3'(bnk);
        continuous_i = 1'b0;
        start_i      = 1'b1;
        due          = cyc + S + 1;
        tick();
        start_i = 1'b0;
        check_eq("busy_after_start", 32'(busy_o), 1);
        check_eq("timeout_cleared_by_start", 32'(timeout_err_o), 0);
        check_eq("F3_bank", f3_sel(), bnk);
        for (int i = 0; i < len; i++) begin
            ch = (first + i) % 64;
            wait_adc_start(200);
            check_eq("adc_start_seen", 32'(adc_start_o), 1);
            if (!adc_start_o) return;
            check_eq("adc_start_time", cyc, due);
            check_eq("cur_addr", 32'(cur_addr_o), ch);
            check_eq("F1_sel", f1_sel(), ch % 8);
            check_eq("F2_sel", f2_sel(), ch / 8);
            if (i == drop_idx) begin
                repeat (T) tick();
                check_eq("timeout_err_set", 32'(timeout_err_o), 1);
                check_eq("no_valid_on_timeout", 32'(ch_valid_o), 0);
                check_eq("frame_done_timeout", 32'(frame_done_o), (i == len - 1) ? 1 : 0);
                due = cyc + 1 + S;
            end else begin
                if (lat > 0) begin
                    // start while busy carries a bogus range; it must be ignored
                    start_i    = 1'b1;
                    ch_first_i = ~6'(first);
                    tick();
                    start_i = 1'b0;
                    repeat (lat - 1) tick();
                end
                adc_done_i = 1'b1;
                due = cyc + S + 2;
                tick();
                adc_done_i = 1'b0;
                exp_vld++;
                check_eq("ch_valid", 32'(ch_valid_o), 1);
                check_eq("valid_addr", 32'(cur_addr_o), ch);
                check_eq("frame_done", 32'(frame_done_o), (i == len - 1) ? 1 : 0);
            end
        end
        tick();
        check_eq("idle_after_frame", 32'(busy_o), 0);
        check_eq("valid_count", vld_cnt - vld0, exp_vld);
        check_eq("frame_done_count", fd_cnt - fd0, 1);
        check_eq("timeout_sticky", 32'(timeout_err_o), (drop_idx >= 0 && drop_idx < len) ? 1 : 0);
    endtask

    initial begin
        int seen, first, len, drop;
        rst_n = 1'b0;
        start_i = 1'b0; stop_i = 1'b0; continuous_i = 1'b0; adc_done_i = 1'b0;
        ch_first_i = '0; ch_last_i = '0; bank_i = '0;
        repeat (3) tick();
        check_eq("rst_cur_addr", 32'(cur_addr_o), 0);
        check_eq("rst_busy", 32'(busy_o), 0);
        check_eq("rst_selects", f1_sel() + f2_sel() + f3_sel(), 0);
        check_eq("rst_adc_start", 32'(adc_start_o), 0);
        check_eq("rst_flags", 32'({ch_valid_o, frame_done_o, timeout_err_o}), 0);
        rst_n = 1'b1;
        tick();

        run_scan(2, 3, 5, -1, 3);      // channels 2,3,4 bank 5
        run_scan(10, 1, 1, -1, 1);     // single channel, F1=2 F2=1
        run_scan(62, 4, 3, -1, 0);     // 62,63,0,1 wrap
        run_scan(2, 3, 7, 1, 2);       // ch 3 times out
        run_scan(4, 2, 0, -1, 2);      // start clears timeout_err

        for (int r = 0; r < 8; r++) begin
            first = int'($urandom_range(0, 63));
            len   = int'($urandom_range(1, 5));
            drop  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            run_scan(first, len, int'($urandom_range(0, 7)), drop, int'($urandom_range(0, 5)));
        end

        // Continuous 0..1, stop during SETTLE of the second pass.
        ch_first_i = 6'd0; ch_last_i = 6'd1; bank_i = 3'd2;
        continuous_i = 1'b1; start_i = 1'b1;
        tick();
        start_i = 1'b0; continuous_i = 1'b0;   // latched at start, must not matter
        for (int i = 0; i < 2; i++) begin
            wait_adc_start(200);
            check_eq("cont_adc_start", 32'(adc_start_o), 1);
            check_eq("cont_addr", 32'(cur_addr_o), i);
            tick();
            adc_done_i = 1'b1;
            tick();
            adc_done_i = 1'b0;
            check_eq("cont_valid", 32'(ch_valid_o), 1);
        end
        check_eq("cont_frame_done", 32'(frame_done_o), 1);
        tick();
        check_eq("cont_restart_addr", 32'(cur_addr_o), 0);
        check_eq("cont_restart_busy", 32'(busy_o), 1);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check_eq("stop_settle_idle", 32'(busy_o), 0);
        seen = 0;
        repeat (S + 8) begin tick(); seen |= int'(adc_start_o); end
        check_eq("no_adc_start_after_stop", seen, 0);

        // Stop during CONVERT: conversion completes, then idle.
        continuous_i = 1'b1; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_adc_start(200);
        check_eq("stopconv_adc_start", 32'(adc_start_o), 1);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        tick();
        adc_done_i = 1'b1;
        tick();
        adc_done_i = 1'b0;
        check_eq("stopconv_valid", 32'(ch_valid_o), 1);
        check_eq("stopconv_no_frame", 32'(frame_done_o), 0);
        tick();
        check_eq("stopconv_idle", 32'(busy_o), 0);
        seen = 0;
        repeat (S + 8) begin tick(); seen |= int'(adc_start_o); end
        check_eq("no_adc_start_after_stopconv", seen, 0);

        // Stop and start together in IDLE: start ignored.
        stop_i = 1'b1; start_i = 1'b1;
        tick();
        stop_i = 1'b0; start_i = 1'b0;
        check_eq("stop_wins_over_start", 32'(busy_o), 0);

        // Asynchronous reset in the middle of CONVERT.
        ch_first_i = 6'd9; ch_last_i = 6'd12; bank_i = 3'd6; continuous_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_adc_start(200);
        check_eq("rst_test_adc_start", 32'(adc_start_o), 1);
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_selects", f1_sel() + f2_sel() + f3_sel(), 0);
        check_eq("async_rst_busy", 32'(busy_o), 0);
        check_eq("async_rst_addr", 32'(cur_addr_o), 0);
        tick();
        rst_n = 1'b1;
        adc_done_i = 1'b1;
        tick();
        adc_done_i = 1'b0;
        check_eq("late_done_ignored", 32'(ch_valid_o), 0);
        check_eq("late_done_idle", 32'(busy_o), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
